setassoc_cache_core: RTL and testbench

Synthesizable set-associative cache tag/data core. It is the responder side of the trace-driven lookup/fill protocol used by the cache benches. A requester presents an address every cycle and receives a registered hit flag and word. On a miss, the requester pulses `enable` with the fill word and the core installs it in a victim way. The victim is chosen by LRU or FIFO replacement. The core sits directly behind the requester and has no backing-memory port; fill data always comes from `data_in`.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_victim_sel.sv | 52 +++++
 rtl/setassoc_cache_core.sv | 144 ++++++++++++++
 tb/tb_setassoc_cache_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and helpers for the set-associative cache core.
package cache_pkg;

   // Replacement-policy codes, derived from the REPLACEMENT string at elaboration.
   localparam int REPL_LRU  = 0;
   localparam int REPL_FIFO = 1;

   // Default address split: 16-byte lines, 16 sets.
   localparam int DEF_BLOCK_BITS = 4;
   localparam int DEF_SET_BITS   = 4;

   // Floor log2; f_bits(1) = 0.
   function automatic int f_bits(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((n >> (i + 1)) > 0) r = i + 1;
      end
      return r;
   endfunction

   // Stored tag width for a 32-bit byte address.
   function automatic int f_tag_bits(input int block_bits, input int set_bits);
      return 32 - block_bits - set_bits;
   endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational victim choice and LRU age update for one cache set.
// One instance serves both the hit path and the fill path: the caller feeds
// back whichever way is being accessed and gets the post-access age vector.
module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int ASSOCIATIVITY = 8,
   parameter int WAY_BITS      = f_bits(ASSOCIATIVITY) + 1,
   parameter int POLICY        = REPL_LRU,
   localparam int IDX_BITS     = f_bits(ASSOCIATIVITY)
) (
   input  logic [ASSOCIATIVITY-1:0]               valid,
   input  logic [ASSOCIATIVITY-1:0][WAY_BITS-1:0] ages,
   input  logic [WAY_BITS-1:0]                    fifo_ptr,
   input  logic [IDX_BITS-1:0]                    access_way,
   output logic [IDX_BITS-1:0]                    victim_way,
   output logic [ASSOCIATIVITY-1:0][WAY_BITS-1:0] ages_next
);

   // Only the low IDX_BITS of the pointer address a way; the rest is headroom.
   logic [WAY_BITS-1:0] unused_ptr;
   assign unused_ptr = fifo_ptr;

   // Victim: FIFO takes the pointer; LRU prefers the lowest invalid way, else the oldest.
   always_comb begin
      victim_way = '0;
      if (POLICY == REPL_FIFO) begin
         victim_way = fifo_ptr[IDX_BITS-1:0];
      end else begin
         for (int w = 0; w < ASSOCIATIVITY; w++) begin
            if (ages[w] == WAY_BITS'(ASSOCIATIVITY - 1)) victim_way = IDX_BITS'(w);
         end
         // Descending scan so the lowest-index invalid way is the last assignment.
         for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (!valid[w]) victim_way = IDX_BITS'(w);
         end
      end
   end

   // Accessed way becomes youngest; every younger way ages by one, keeping a permutation.
   always_comb begin
      ages_next = ages;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
         if (IDX_BITS'(w) == access_way) begin
            ages_next[w] = '0;
         end else if (ages[w] < ages[access_way]) begin
            ages_next[w] = ages[w] + WAY_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/setassoc_cache_core.sv
// Set-associative tag/data core answering a lookup/fill requester.
// Protocol: the requester presents address_in every cycle with enable=0 and
// sees hit_out/data_out one edge later. After a miss it holds the address and
// pulses enable for exactly one edge with the fill word on data_in; the core
// installs the line at that edge and reports hit_out=1, data_out=data_in.
module setassoc_cache_core
   import cache_pkg::*;
#(
   parameter int    ASSOCIATIVITY = 8,
   parameter int    WAY_BITS      = f_bits(ASSOCIATIVITY) + 1,
   parameter int    SET_BITS      = DEF_SET_BITS,
   parameter int    BLOCK_BITS    = DEF_BLOCK_BITS,
   parameter int    TAG_BITS      = f_tag_bits(BLOCK_BITS, SET_BITS),
   parameter string REPLACEMENT   = "LRU"
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [31:0] address_in,
   input  logic [31:0] data_in,
   output logic        hit_out,
   output logic [31:0] data_out
);

   localparam int IDX_BITS = f_bits(ASSOCIATIVITY);
   localparam int SETS     = 1 << SET_BITS;
   localparam int POLICY   = (REPLACEMENT == "LRU")  ? REPL_LRU  :
                             (REPLACEMENT == "FIFO") ? REPL_FIFO : -1;

   if (POLICY < 0) begin : g_bad_policy
      $error("setassoc_cache_core: REPLACEMENT must be \"LRU\" or \"FIFO\"");
   end
   if ((1 << IDX_BITS) != ASSOCIATIVITY || ASSOCIATIVITY < 2) begin : g_bad_assoc
      $error("setassoc_cache_core: ASSOCIATIVITY must be a power of two >= 2");
   end
   if (WAY_BITS < IDX_BITS) begin : g_bad_way_bits
      $error("setassoc_cache_core: WAY_BITS too narrow for ASSOCIATIVITY");
   end

   // Line and set state. Tags and words carry no reset; valid bits guard them.
   logic [ASSOCIATIVITY-1:0]               valid_q [SETS];
   logic [ASSOCIATIVITY-1:0][WAY_BITS-1:0] age_q   [SETS];
   logic [WAY_BITS-1:0]                    ptr_q   [SETS];
   logic [TAG_BITS-1:0]                    tag_q   [SETS][ASSOCIATIVITY];
   logic [31:0]                            data_q  [SETS][ASSOCIATIVITY];

   // Address decode; the byte offset selects nothing with one word per line.
   logic [SET_BITS-1:0]   set_idx;
   logic [TAG_BITS-1:0]   tag;
   logic [BLOCK_BITS-1:0] unused_offset;
   assign set_idx       = address_in[BLOCK_BITS +: SET_BITS];
   assign tag           = address_in[31 -: TAG_BITS];
   assign unused_offset = address_in[BLOCK_BITS-1:0];

   // Current set's state, seen by the compare and replacement logic.
   logic [ASSOCIATIVITY-1:0]               set_valid;
   logic [ASSOCIATIVITY-1:0][WAY_BITS-1:0] set_age;
   logic [WAY_BITS-1:0]                    set_ptr;
   assign set_valid = valid_q[set_idx];
   assign set_age   = age_q[set_idx];
   assign set_ptr   = ptr_q[set_idx];

   logic [ASSOCIATIVITY-1:0]               match;
   logic [IDX_BITS-1:0]                    hit_way;
   logic                                   hit;
   logic [IDX_BITS-1:0]                    victim_way;
   logic [IDX_BITS-1:0]                    acc_way;
   logic [ASSOCIATIVITY-1:0][WAY_BITS-1:0] age_next;
   logic [WAY_BITS-1:0]                    ptr_inc;
   logic                                   alloc;
   logic                                   touch;

   // Tag compare across the ways of the addressed set; at most one way can match.
   always_comb begin
      match   = '0;
      hit_way = '0;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
         match[w] = set_valid[w] && (tag_q[set_idx][w] == tag);
         if (match[w]) hit_way = IDX_BITS'(w);
      end
   end

   assign hit     = |match;
   // A resident tag is overwritten in place; only a true miss allocates.
   assign acc_way = hit ? hit_way : victim_way;
   assign alloc   = enable && !hit;
   assign touch   = (POLICY == REPL_LRU) && (hit || enable);
   assign ptr_inc = WAY_BITS'(set_ptr[IDX_BITS-1:0] + IDX_BITS'(1));

   cache_victim_sel #(
      .ASSOCIATIVITY (ASSOCIATIVITY),
      .WAY_BITS      (WAY_BITS),
      .POLICY        ((POLICY == REPL_FIFO) ? REPL_FIFO : REPL_LRU)
   ) u_victim_sel (
      .valid      (set_valid),
      .ages       (set_age),
      .fifo_ptr   (set_ptr),
      .access_way (acc_way),
      .victim_way (victim_way),
      .ages_next  (age_next)
   );

   // Tag and word write on a fill; no reset so these map onto plain storage.
   always_ff @(posedge clk) begin
      if (enable) begin
         tag_q[set_idx][acc_way]  <= tag;
         data_q[set_idx][acc_way] <= data_in;
      end
   end

   // Valid bits, replacement state and the registered lookup/fill result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
               age_q[s][w] <= WAY_BITS'(w);
            end
         end
         hit_out  <= 1'b0;
         data_out <= '0;
      end else begin
         if (enable) begin
            valid_q[set_idx][acc_way] <= 1'b1;
         end
         if (alloc && (POLICY == REPL_FIFO)) begin
            ptr_q[set_idx] <= ptr_inc;
         end
         if (touch) begin
            age_q[set_idx] <= age_next;
         end
         hit_out <= enable || hit;
         if (enable) begin
            data_out <= data_in;
         end else if (hit) begin
            data_out <= data_q[set_idx][hit_way];
         end else begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_setassoc_cache_core.sv
// Bench for setassoc_cache_core: an LRU and a FIFO instance see identical
// stimulus; a behavioural model (recency lists for LRU, a pointer for FIFO)
// predicts each output word, which is queued and compared one edge later.
module tb_setassoc_cache_core;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] address_in = '0;
   logic [31:0] data_in = '0;
   logic        hit_l, hit_f;
   logic [31:0] data_l, data_f;

   int n_cmp = 0;
   int n_bad = 0;

   logic [32:0] exp_q_lru[$];
   logic [32:0] exp_q_fifo[$];

   // Reference state: index 0 = LRU instance, 1 = FIFO instance.
   bit          mv [2][16][8];
   logic [23:0] mt [2][16][8];
   logic [31:0] md [2][16][8];
   int          ord [16][8];   // LRU recency list, most recent first
   int          mptr [16];

   always #5 clk = ~clk;

   setassoc_cache_core #(.REPLACEMENT("LRU")) dut_lru (
      .clk(clk), .rst(rst), .enable(enable), .address_in(address_in),
      .data_in(data_in), .hit_out(hit_l), .data_out(data_l)
   );

   setassoc_cache_core #(.REPLACEMENT("FIFO")) dut_fifo (
      .clk(clk), .rst(rst), .enable(enable), .address_in(address_in),
      .data_in(data_in), .hit_out(hit_f), .data_out(data_f)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < 16; s++)
            for (int w = 0; w < 8; w++) mv[p][s][w] = 1'b0;
      for (int s = 0; s < 16; s++) begin
         mptr[s] = 0;
         for (int i = 0; i < 8; i++) ord[s][i] = i;
      end
   endtask

   task automatic touch(input int s, input int a);
      int i;
      i = 0;
      for (int k = 0; k < 8; k++) if (ord[s][k] == a) i = k;
      for (int k = i; k > 0; k--) ord[s][k] = ord[s][k-1];
      ord[s][0] = a;
   endtask

   task automatic model_step(input int p, input bit en, input logic [31:0] addr,
                             input logic [31:0] din, output logic [32:0] e);
      int s;
      int hw;
      int v;
      logic [23:0] t;
      s  = int'(addr[7:4]);
      t  = addr[31:8];
      hw = -1;
      for (int w = 0; w < 8; w++) if (mv[p][s][w] && mt[p][s][w] == t) hw = w;
      if (!en) begin
         if (hw >= 0) begin
            e = {1'b1, md[p][s][hw]};
            if (p == 0) touch(s, hw);
         end else begin
            e = '0;
         end
      end else begin
         if (hw >= 0) begin
            v = hw;
         end else if (p == 0) begin
            v = -1;
            for (int w = 7; w >= 0; w--) if (!mv[p][s][w]) v = w;
            if (v < 0) v = ord[s][7];
         end else begin
            v = mptr[s];
            mptr[s] = (mptr[s] + 1) % 8;
         end
         mv[p][s][v] = 1'b1;
         mt[p][s][v] = t;
         md[p][s][v] = din;
         if (p == 0) touch(s, v);
         e = {1'b1, din};
      end
   endtask

   // LRU ages must equal each way's position in the model's recency list.
   task automatic check_ages(input int s);
      logic [31:0] e;
      e = '0;
      for (int w = 0; w < 8; w++)
         for (int i = 0; i < 8; i++)
            if (ord[s][i] == w) e[w*4 +: 4] = 4'(i);
      check_eq($sformatf("age_set%0d", s), 64'(dut_lru.age_q[s]), 64'(e));
   endtask

   task automatic cycle(input bit en, input logic [31:0] addr, input logic [31:0] din,
                        output logic [32:0] ol, output logic [32:0] of);
      logic [32:0] e;
      enable     = en;
      address_in = addr;
      data_in    = din;
      model_step(0, en, addr, din, e);
      exp_q_lru.push_back(e);
      model_step(1, en, addr, din, e);
      exp_q_fifo.push_back(e);
      @(posedge clk);
      #1;
      ol = {hit_l, data_l};
      of = {hit_f, data_f};
      check_eq("lru_out", 64'(ol), 64'(exp_q_lru.pop_front()));
      check_eq("fifo_out", 64'(of), 64'(exp_q_fifo.pop_front()));
      check_ages(int'(addr[7:4]));
      enable = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst    = 1'b0;
      #1;
      check_eq("rst_lru_out", 64'({hit_l, data_l}), 64'd0);
      check_eq("rst_fifo_out", 64'({hit_f, data_f}), 64'd0);
      model_reset();
      exp_q_lru.delete();
      exp_q_fifo.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_eq("rst_ages", 64'(dut_lru.age_q[0]), 64'h7654_3210);
      check_eq("rst_fifo_ptr", 64'(dut_fifo.ptr_q[0]), 64'd0);
   endtask

   logic [32:0] ol, of;

   initial begin
      // 1: lookup after reset misses
      do_reset();
      cycle(1'b0, 32'h0000_0100, '0, ol, of);
      check_eq("t1_miss", 64'(ol), 64'd0);

      // 2: fill then hit on another byte of the same line
      cycle(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, ol, of);
      check_eq("t2_fill_out", 64'(ol), {31'd0, 1'b1, 32'hDEAD_BEEF});
      cycle(1'b0, 32'h0000_0104, '0, ol, of);
      check_eq("t2_hit_lru", 64'(ol), {31'd0, 1'b1, 32'hDEAD_BEEF});
      check_eq("t2_hit_fifo", 64'(of), {31'd0, 1'b1, 32'hDEAD_BEEF});

      // 3: nine fills into set 0 evict the first line
      do_reset();
      for (int i = 0; i < 9; i++) cycle(1'b1, 32'(i << 8), 32'h1000 + 32'(i), ol, of);
      cycle(1'b0, 32'h0000_0000, '0, ol, of);
      check_eq("t3_evict_lru", 64'(ol[32]), 64'd0);
      cycle(1'b0, 32'h0000_0100, '0, ol, of);
      check_eq("t3_keep_lru", 64'(ol), {31'd0, 1'b1, 32'h1001});

      // 4/5: touching line 0 protects it under LRU but not under FIFO
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i << 8), 32'h2000 + 32'(i), ol, of);
      cycle(1'b0, 32'h0000_0000, '0, ol, of);
      check_eq("t4_touch_lru", 64'(ol), {31'd0, 1'b1, 32'h2000});
      cycle(1'b1, 32'h0000_0800, 32'h2008, ol, of);
      check_eq("t5_fifo_ptr", 64'(dut_fifo.ptr_q[0]), 64'd1);
      cycle(1'b0, 32'h0000_0000, '0, ol, of);
      check_eq("t4_kept_lru", 64'(ol[32]), 64'd1);
      check_eq("t5_evict_fifo", 64'(of[32]), 64'd0);
      cycle(1'b0, 32'h0000_0100, '0, ol, of);
      check_eq("t4_evict_lru", 64'(ol[32]), 64'd0);
      check_eq("t5_keep_fifo", 64'(of), {31'd0, 1'b1, 32'h2001});

      // Random mix of lookups, fills and overwrites over two sets
      do_reset();
      repeat (300) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 11)) << 8) | (32'($urandom_range(0, 1)) << 4)
             | 32'($urandom_range(0, 15));
         cycle($urandom_range(0, 2) == 0, a, $urandom, ol, of);
      end

      // 6: reset dropped between edges during a fill
      cycle(1'b1, 32'h0000_0300, 32'hAAAA_5555, ol, of);
      enable     = 1'b1;
      address_in = 32'h0000_0900;
      data_in    = 32'h1234_5678;
      #2;
      rst = 1'b0;
      #1;
      check_eq("t6_async_lru", 64'({hit_l, data_l}), 64'd0);
      check_eq("t6_async_fifo", 64'({hit_f, data_f}), 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      rst    = 1'b1;
      for (int t = 0; t < 12; t++) begin
         for (int s = 0; s < 2; s++) begin
            cycle(1'b0, 32'((t << 8) | (s << 4)), '0, ol, of);
            check_eq("t6_miss_lru", 64'(ol[32]), 64'd0);
            check_eq("t6_miss_fifo", 64'(of[32]), 64'd0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
